// File: rtl/sa_cache_wb.sv
// Set-associative, write-back, write-allocate cache with tree-PLRU replacement.
// CPU side issues one word request at a time; memory side moves 256-bit lines.
// Handshakes: the CPU holds a request (nonzero rmask or wmask) stable until
// ufp_resp=1 for one cycle; the cache holds dfp_read or dfp_write (never both)
// and its dfp_addr/dfp_wdata stable until memory answers with dfp_resp=1.
module sa_cache_wb #(
   parameter int NUM_WAYS = 4,
   parameter int NUM_SETS = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  ufp_addr,
   input  logic [3:0]   ufp_rmask,
   input  logic [3:0]   ufp_wmask,
   input  logic [31:0]  ufp_wdata,
   output logic [31:0]  ufp_rdata,
   output logic         ufp_resp,
   output logic [31:0]  dfp_addr,
   output logic         dfp_read,
   output logic         dfp_write,
   input  logic [255:0] dfp_rdata,
   output logic [255:0] dfp_wdata,
   input  logic         dfp_resp,
   output logic [1:0]   o_dbg_state
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(NUM_WAYS);
   localparam int TAG_W = 27 - IDX_W;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_COMPARE   = 2'd1;
   localparam logic [1:0] S_WRITEBACK = 2'd2;
   localparam logic [1:0] S_ALLOCATE  = 2'd3;

   logic [1:0]          r_state;
   logic [31:2]         r_addr;
   logic [3:0]          r_wmask;
   logic [31:0]         r_wdata;
   logic [WAY_W-1:0]    r_victim;
   logic [255:0]        r_data  [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
   logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
   logic [NUM_WAYS-2:0] r_plru  [NUM_SETS];

   logic                w_req;
   logic                w_unused_addr_lsbs;
   logic [IDX_W-1:0]    w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic [2:0]          w_word;
   logic                w_hit;
   logic [WAY_W-1:0]    w_hit_way;
   logic [WAY_W-1:0]    w_victim_way;
   logic [31:0]         w_old_word;
   logic [31:0]         w_new_word;

   // Tree walk: node n has children 2n and 2n+1; a 0 bit sends the victim left.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] p);
      int node;
      node = 1;
      for (int l = 0; l < WAY_W; l++) node = 2 * node + (p[node-1] ? 1 : 0);
      return WAY_W'(node - NUM_WAYS);
   endfunction

   // Every node on the path to the used way is pointed at the other subtree.
   function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] p,
                                                      input logic [WAY_W-1:0] way);
      logic [NUM_WAYS-2:0] q;
      logic                dir;
      int                  node;
      q    = p;
      node = 1;
      for (int l = 0; l < WAY_W; l++) begin
         dir       = way[WAY_W-1-l];
         q[node-1] = ~dir;
         node      = 2 * node + (dir ? 1 : 0);
      end
      return q;
   endfunction

   assign w_req              = (|ufp_rmask) || (|ufp_wmask);
   assign w_unused_addr_lsbs = ^ufp_addr[1:0];
   assign w_idx              = r_addr[5 +: IDX_W];
   assign w_tag              = r_addr[31 -: TAG_W];
   assign w_word             = r_addr[4:2];
   assign w_old_word         = r_data[w_idx][w_hit_way][{w_word, 5'b0} +: 32];
   assign o_dbg_state        = r_state;

   // Tag lookup across all ways of the indexed set.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
   end

   // Victim: lowest invalid way, otherwise the PLRU way.
   always_comb begin
      w_victim_way = plru_victim(r_plru[w_idx]);
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w_idx][w]) w_victim_way = WAY_W'(w);
      end
   end

   // Byte-merge of the write data into the hit word.
   always_comb begin
      w_new_word = w_old_word;
      for (int b = 0; b < 4; b++) begin
         if (r_wmask[b]) w_new_word[8*b +: 8] = r_wdata[8*b +: 8];
      end
   end

   // CPU response: only in the hit cycle of COMPARE, zero otherwise (pre-write word on RMW).
   assign ufp_resp  = (r_state == S_COMPARE) && w_hit;
   assign ufp_rdata = ufp_resp ? w_old_word : 32'd0;
   assign dfp_read  = (r_state == S_ALLOCATE);
   assign dfp_write = (r_state == S_WRITEBACK);

   // Memory-side address/data, forced to zero when no memory request is active.
   always_comb begin
      dfp_addr  = 32'd0;
      dfp_wdata = '0;
      if (r_state == S_WRITEBACK) begin
         dfp_addr  = {r_tag[w_idx][r_victim], w_idx, 5'b0};
         dfp_wdata = r_data[w_idx][r_victim];
      end else if (r_state == S_ALLOCATE) begin
         dfp_addr  = {w_tag, w_idx, 5'b0};
      end
   end

   // Request capture when leaving IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_wmask <= '0;
         r_wdata <= '0;
      end else if ((r_state == S_IDLE) && w_req) begin
         r_addr  <= ufp_addr[31:2];
         r_wmask <= ufp_wmask;
         r_wdata <= ufp_wdata;
      end
   end

   // Controller FSM plus valid/dirty/PLRU bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_victim <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            r_plru[s]  <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) r_state <= S_COMPARE;
            end
            S_COMPARE: begin
               if (w_hit) begin
                  r_state       <= S_IDLE;
                  r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
                  if (|r_wmask) r_dirty[w_idx][w_hit_way] <= 1'b1;
               end else begin
                  r_victim <= w_victim_way;
                  if (r_valid[w_idx][w_victim_way] && r_dirty[w_idx][w_victim_way])
                     r_state <= S_WRITEBACK;
                  else
                     r_state <= S_ALLOCATE;
               end
            end
            S_WRITEBACK: begin
               if (dfp_resp) r_state <= S_ALLOCATE;
            end
            default: begin
               if (dfp_resp) begin
                  r_valid[w_idx][r_victim] <= 1'b1;
                  r_dirty[w_idx][r_victim] <= 1'b0;
                  r_state                  <= S_COMPARE;
               end
            end
         endcase
      end
   end

   // Line and tag storage: filled on ALLOCATE completion, word-merged on write hits.
   always_ff @(posedge clk) begin
      if ((r_state == S_ALLOCATE) && dfp_resp) begin
         r_data[w_idx][r_victim] <= dfp_rdata;
         r_tag[w_idx][r_victim]  <= w_tag;
      end else if ((r_state == S_COMPARE) && w_hit && (|r_wmask)) begin
         r_data[w_idx][w_hit_way][{w_word, 5'b0} +: 32] <= w_new_word;
      end
   end

endmodule
